elevator_ctrl_n: RTL and testbench
==================================

# elevator_ctrl_n

Parametrised N-floor elevator controller, the successor to the fixed 4-floor `elevator` block. It latches hall and car calls into per-floor request registers that drive the button LEDs. It schedules service with a collective up/down sweep and times floor-to-floor travel and the door dwell with internal counters. A door-hold input is new in this generation. All outputs are registered and drive the panel/indicator logic directly.

## Interface
- `NFLOORS`, default 4: number of floors, minimum 2.
- `FW`, default 2: floor index width, equal to ceil(log2(NFLOORS)).
- `TRAVEL_CYC`, default 4: clock cycles per one-floor move, minimum 1.
- `DOOR_CYC`, default 3: cycles the door stays open, minimum 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hall_up` in NFLOORS: up hall call per floor. Bit NFLOORS-1 is ignored.
- `hall_dn` in NFLOORS: down hall call per floor. Bit 0 is ignored.
- `car_call` in NFLOORS: in-car floor buttons.
- `door_hold` in 1: while high during DOOR, the dwell timer is reloaded.
- `up_led` out NFLOORS: latched up requests. Bit NFLOORS-1 is always 0.
- `dn_led` out NFLOORS: latched down requests. Bit 0 is always 0.
- `car_led` out NFLOORS: latched car requests.
- `door_open` out 1: high while in DOOR.
- `direction` out 2: 00 idle, 01 up, 10 down. 11 is never driven.
- `floor` out FW: current floor, 0..NFLOORS-1.

## Operation
- **Request latching.** Each edge, every LED register becomes `led | masked input`. A clear at the same edge wins only for a bit being served at that edge.
- **"Ahead" / "behind".** "Ahead" = any LED bit strictly above `floor` (up) or strictly below it (down). "Behind" is the opposite side.
- **States.** Three states: IDLE, MOVE, DOOR.
- **IDLE, call at current floor.** If any LED bit at the current floor is set → DOOR. Clear `car_led`, `up_led` and `dn_led` at that floor. `direction` = 00.
- **IDLE, calls elsewhere.**
  - Else if any request is above → MOVE, `direction` = 01.
  - Else if any request is below → MOVE, `direction` = 10.
  - Up wins when requests exist on both sides.
- **MOVE, travel.** The travel counter is loaded with TRAVEL_CYC-1 on entry and decrements each cycle. At the edge where it is 0, `floor` steps ±1.
- **MOVE, stop decision.** The decision at that same edge uses the new floor. Stop if any of these hold:
  - `car_led` at the new floor is set;
  - the hall bit in the current direction at the new floor is set;
  - there is nothing ahead of the new floor. In this case the opposite hall bit is also served.
- **MOVE, on stop.** → DOOR, clear the served bits, `door_open` = 1 at that edge. Otherwise reload the counter and stay in MOVE.
- **MOVE, end floors.** `floor` never passes 0 or NFLOORS-1. Reaching an end floor always satisfies "nothing ahead".
- **DOOR, dwell.** The dwell counter is loaded with DOOR_CYC-1 and decrements. `door_hold` = 1 reloads it to DOOR_CYC-1.
- **DOOR, new call at current floor.** A car call or same-direction hall call at the current floor is not latched. Its LED stays 0 and the dwell counter is reloaded.
- **DOOR, expiry.** When the counter is 0 and `door_hold` = 0:
  - if requests are ahead → MOVE in the same direction;
  - else → IDLE with `direction` = 00, and IDLE re-evaluates at the next edge. This is how reversal and opposite-direction calls at the current floor get served.
- **Reset.** `rst` at any edge, including mid-MOVE or mid-DOOR, has priority over everything. It forces IDLE, `floor` = 0, `direction` = 00, `door_open` = 0, all LEDs 0 and counters 0. Inputs sampled at that edge are discarded.

## Timing
- Latency from a call edge to its LED = 1 edge.
- IDLE decision occurs at the edge after the LED sets.
- Arrival at a floor k away takes k·TRAVEL_CYC edges after MOVE entry. `door_open` rises on the same edge as the final `floor` update.
- The door is open for exactly DOOR_CYC cycles when there is no hold and no re-press.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- **Reset.** `rst` = 1 for 2 cycles with calls asserted → all LEDs 0, `floor` = 0, `direction` = 00, `door_open` = 0. Check at the first edge after `rst` falls.
- **Single hall call, defaults.** At floor 0, pulse `hall_up[2]` at edge 0:
  - `up_led[2]` = 1 after edge 0;
  - MOVE with `direction` = 01 after edge 1;
  - `floor` = 1 at edge 5;
  - `floor` = 2 with `door_open` = 1 and `up_led[2]` = 0 at edge 9;
  - IDLE with `direction` = 00 at edge 12.
- **Car calls during dwell.** Continue from the previous scenario. Pulse `car_call[3]` and `car_call[2]` during DOOR:
  - `car_led[2]` stays 0 and the dwell counter reloads;
  - `car_led[3]` = 1;
  - after expiry, the car moves up with no IDLE cycle and stops at floor 3.
- **Sweep order.** At floor 1 moving up toward 3, `dn_led[2]` set → the car passes floor 2 without stopping and serves 3. It then goes IDLE, reverses down, and stops at 2.
- **Door hold.** `door_hold` held for 5 cycles in DOOR → `door_open` stays 1 for 5 + DOOR_CYC cycles total from the hold start.
- **Reset mid-move.** `rst` asserted mid-MOVE between floors 2 and 3 → the next edge gives `floor` = 0, IDLE, all LEDs cleared.
- **Parameter variant.** Run NFLOORS = 6, FW = 3 with `car_call[5]` from floor 0 → arrival after 20 edges at defaults. `hall_up[5]` and `hall_dn[0]` are never latched.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n
// ---------------------------------------------------------------------------
// Parametrised N-floor elevator controller with a collective up/down sweep.
// Hall and car calls are latched into per-floor request registers that also
// drive the button LEDs. A shared down-counter times both the floor-to-floor
// travel (MOVE) and the door dwell (DOOR).
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset (wins over everything)
//   hall_up    : up hall calls per floor (top floor bit ignored)
//   hall_dn    : down hall calls per floor (floor 0 bit ignored)
//   car_call   : in-car floor buttons
//   door_hold  : while high in DOOR, reloads the dwell timer
//   up_led     : latched up requests (top bit always 0)
//   dn_led     : latched down requests (bit 0 always 0)
//   car_led    : latched car requests
//   door_open  : high while in DOOR
//   direction  : 00 idle, 01 up, 10 down
//   floor      : current floor index
//   dbg_state  : FSM state (0 IDLE, 1 MOVE, 2 DOOR)
//
// Handshake: there is no valid/ready pairing here; every input is a level
// sampled on each rising edge and every output is a flop.
// ---------------------------------------------------------------------------
module elevator_ctrl_n #(
  parameter int NFLOORS    = 4,
  parameter int FW         = 2,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] hall_up,
  input  logic [NFLOORS-1:0] hall_dn,
  input  logic [NFLOORS-1:0] car_call,
  input  logic               door_hold,
  output logic [NFLOORS-1:0] up_led,
  output logic [NFLOORS-1:0] dn_led,
  output logic [NFLOORS-1:0] car_led,
  output logic               door_open,
  output logic [1:0]         direction,
  output logic [FW-1:0]      floor,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  // One counter serves both travel and dwell, so size it for the larger load.
  localparam int CMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYC - 1);

  localparam logic [FW-1:0]      TOP_FLOOR = FW'(NFLOORS - 1);
  localparam logic [NFLOORS-1:0] UP_MASK   = {1'b0, {(NFLOORS-1){1'b1}}};
  localparam logic [NFLOORS-1:0] DN_MASK   = {{(NFLOORS-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic [1:0]          dir_q, dir_d;
  logic                door_open_q, door_open_d;
  logic [NFLOORS-1:0]  up_q, up_d, dn_q, dn_d, car_q, car_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Combinational helpers
  logic [NFLOORS-1:0]  req_q;
  logic [NFLOORS-1:0]  fsel, nsel;
  logic [NFLOORS-1:0]  up_set, dn_set, car_set;
  logic [NFLOORS-1:0]  up_clr, dn_clr, car_clr;
  logic [FW-1:0]       nf;
  logic                ahead_nf, ahead_cur, stop_now, press;

  function automatic logic any_above(input logic [NFLOORS-1:0] r,
                                     input logic [FW-1:0] f);
    logic res;
    res = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (FW'(i) > f && r[i]) res = 1'b1;
    end
    return res;
  endfunction

  function automatic logic any_below(input logic [NFLOORS-1:0] r,
                                     input logic [FW-1:0] f);
    logic res;
    res = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (FW'(i) < f && r[i]) res = 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_q;
    door_open_d = door_open_q;
    cnt_d       = cnt_q;

    req_q   = up_q | dn_q | car_q;
    fsel    = NFLOORS'(1) << floor_q;
    up_set  = hall_up & UP_MASK;
    dn_set  = hall_dn & DN_MASK;
    car_set = car_call;
    up_clr  = '0;
    dn_clr  = '0;
    car_clr = '0;

    nf       = floor_q;
    nsel     = fsel;
    ahead_nf = 1'b0;
    stop_now = 1'b0;
    press    = 1'b0;
    ahead_cur = (dir_q == DIR_UP) ? any_above(req_q, floor_q) :
                (dir_q == DIR_DN) ? any_below(req_q, floor_q) : 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        dir_d = DIR_IDLE;
        if (|(req_q & fsel)) begin
          state_d     = ST_DOOR;
          door_open_d = 1'b1;
          cnt_d       = DOOR_LOAD;
          up_clr      = fsel;
          dn_clr      = fsel;
          car_clr     = fsel;
        end else if (any_above(req_q, floor_q)) begin
          state_d = ST_MOVE;
          dir_d   = DIR_UP;
          cnt_d   = TRAVEL_LOAD;
        end else if (any_below(req_q, floor_q)) begin
          state_d = ST_MOVE;
          dir_d   = DIR_DN;
          cnt_d   = TRAVEL_LOAD;
        end
      end

      ST_MOVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Step one floor; saturate at the ends so floor can never wrap.
          if (dir_q == DIR_UP && floor_q != TOP_FLOOR) nf = floor_q + FW'(1);
          if (dir_q == DIR_DN && floor_q != '0)        nf = floor_q - FW'(1);
          floor_d  = nf;
          nsel     = NFLOORS'(1) << nf;
          ahead_nf = (dir_q == DIR_UP) ? any_above(req_q, nf) : any_below(req_q, nf);
          stop_now = (|(car_q & nsel)) || !ahead_nf ||
                     ((dir_q == DIR_UP) ? |(up_q & nsel) : |(dn_q & nsel));
          if (stop_now) begin
            state_d     = ST_DOOR;
            door_open_d = 1'b1;
            cnt_d       = DOOR_LOAD;
            car_clr     = nsel;
            // Last stop of the sweep also serves the opposite hall call.
            if (dir_q == DIR_UP || !ahead_nf) up_clr = nsel;
            if (dir_q == DIR_DN || !ahead_nf) dn_clr = nsel;
          end else begin
            cnt_d = TRAVEL_LOAD;
          end
        end
      end

      ST_DOOR: begin
        // Calls that the open door already serves are swallowed and only
        // extend the dwell. With no direction both hall calls count.
        press   = |(car_call & fsel);
        car_set = car_set & ~fsel;
        if (dir_q != DIR_DN) begin
          press  = press | (|(up_set & fsel));
          up_set = up_set & ~fsel;
        end
        if (dir_q != DIR_UP) begin
          press  = press | (|(dn_set & fsel));
          dn_set = dn_set & ~fsel;
        end

        if (door_hold || press) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (ahead_cur) begin
          state_d     = ST_MOVE;
          door_open_d = 1'b0;
          cnt_d       = TRAVEL_LOAD;
        end else begin
          // IDLE re-evaluates next edge: handles reversal and opposite calls here.
          state_d     = ST_IDLE;
          door_open_d = 1'b0;
          dir_d       = DIR_IDLE;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    up_d  = (up_q  | up_set)  & ~up_clr;
    dn_d  = (dn_q  | dn_set)  & ~dn_clr;
    car_d = (car_q | car_set) & ~car_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      floor_q     <= '0;
      dir_q       <= DIR_IDLE;
      door_open_q <= 1'b0;
      up_q        <= '0;
      dn_q        <= '0;
      car_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      door_open_q <= door_open_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      car_q       <= car_d;
      cnt_q       <= cnt_d;
    end
  end

  assign up_led    = up_q;
  assign dn_led    = dn_q;
  assign car_led   = car_q;
  assign door_open = door_open_q;
  assign direction = dir_q;
  assign floor     = floor_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
module tb_elevator_ctrl_n;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] hall_up, hall_dn, car_call;
  logic       door_hold;
  logic [3:0] up_led, dn_led, car_led;
  logic       door_open;
  logic [1:0] direction, st;
  logic [1:0] floor;

  logic       rst6;
  logic [5:0] hall_up6, hall_dn6, car_call6;
  logic       door_hold6;
  logic [5:0] up_led6, dn_led6, car_led6;
  logic       door_open6;
  logic [1:0] direction6, st6;
  logic [2:0] floor6;

  elevator_ctrl_n dut (
    .clk(clk), .rst(rst), .hall_up(hall_up), .hall_dn(hall_dn),
    .car_call(car_call), .door_hold(door_hold), .up_led(up_led),
    .dn_led(dn_led), .car_led(car_led), .door_open(door_open),
    .direction(direction), .floor(floor), .dbg_state(st)
  );

  elevator_ctrl_n #(.NFLOORS(6), .FW(3), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut6 (
    .clk(clk), .rst(rst6), .hall_up(hall_up6), .hall_dn(hall_dn6),
    .car_call(car_call6), .door_hold(door_hold6), .up_led(up_led6),
    .dn_led(dn_led6), .car_led(car_led6), .door_open(door_open6),
    .direction(direction6), .floor(floor6), .dbg_state(st6)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int e;  // edge index within the current scenario

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  task automatic clear_inputs();
    hall_up = '0; hall_dn = '0; car_call = '0; door_hold = 1'b0;
  endtask

  // Reset with calls asserted; check right after the first edge with rst low.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    hall_up = 4'b1111; hall_dn = 4'b1111; car_call = 4'b1111;
    tick(); tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    chk({tag, "_up"},    up_led, 0);
    chk({tag, "_dn"},    dn_led, 0);
    chk({tag, "_car"},   car_led, 0);
    chk({tag, "_floor"}, floor, 0);
    chk({tag, "_dir"},   direction, 0);
    chk({tag, "_door"},  door_open, 0);
    e = -1;
  endtask

  // hall_up[2] from floor 0 up to the door opening at floor 2 (edge 9)
  task automatic up_to_floor2();
    hall_up = 4'b0100;
    tick();  // edge 0
    clear_inputs();
    run_to(9);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    rst6 = 1'b1;
    hall_up6 = '0; hall_dn6 = '0; car_call6 = '0; door_hold6 = 1'b0;
    e = -1;

    // ---- reset ----
    do_reset("rst");

    // ---- single hall call ----
    hall_up = 4'b0100;
    tick();  // edge 0
    clear_inputs();
    chk("s1_led_e0", up_led, 4'b0100);
    chk("s1_st_e0", st, S_IDLE);
    tick();
    chk("s1_st_e1", st, S_MOVE);
    chk("s1_dir_e1", direction, 2'b01);
    run_to(4);
    chk("s1_floor_e4", floor, 0);
    tick();
    chk("s1_floor_e5", floor, 1);
    run_to(8);
    chk("s1_floor_e8", floor, 1);
    chk("s1_door_e8", door_open, 0);
    tick();
    chk("s1_floor_e9", floor, 2);
    chk("s1_door_e9", door_open, 1);
    chk("s1_led_e9", up_led, 0);
    run_to(11);
    chk("s1_door_e11", door_open, 1);
    tick();
    chk("s1_st_e12", st, S_IDLE);
    chk("s1_dir_e12", direction, 0);
    chk("s1_door_e12", door_open, 0);

    // ---- car calls during dwell ----
    do_reset("rst2");
    up_to_floor2();
    car_call = 4'b1100;
    tick();  // edge 10
    clear_inputs();
    chk("s2_car_e10", car_led, 4'b1000);
    run_to(12);
    chk("s2_reload_e12", st, S_DOOR);
    tick();
    chk("s2_st_e13", st, S_MOVE);
    chk("s2_dir_e13", direction, 2'b01);
    chk("s2_door_e13", door_open, 0);
    run_to(16);
    chk("s2_floor_e16", floor, 2);
    tick();
    chk("s2_floor_e17", floor, 3);
    chk("s2_door_e17", door_open, 1);
    chk("s2_car_e17", car_led, 0);

    // ---- sweep order ----
    do_reset("rst3");
    car_call = 4'b1000;
    tick();  // edge 0
    clear_inputs();
    run_to(5);
    chk("s3_floor_e5", floor, 1);
    hall_dn = 4'b0100;
    tick();  // edge 6
    clear_inputs();
    chk("s3_dn_e6", dn_led, 4'b0100);
    run_to(9);
    chk("s3_floor_e9", floor, 2);
    chk("s3_pass_e9", st, S_MOVE);
    run_to(13);
    chk("s3_floor_e13", floor, 3);
    chk("s3_st_e13", st, S_DOOR);
    chk("s3_car_e13", car_led, 0);
    chk("s3_dn_e13", dn_led, 4'b0100);
    run_to(16);
    chk("s3_st_e16", st, S_IDLE);
    tick();
    chk("s3_st_e17", st, S_MOVE);
    chk("s3_dir_e17", direction, 2'b10);
    run_to(20);
    chk("s3_floor_e20", floor, 3);
    tick();
    chk("s3_floor_e21", floor, 2);
    chk("s3_door_e21", door_open, 1);
    chk("s3_dn_e21", dn_led, 0);

    // ---- door hold: 5 held edges, door open 5+3 cycles from hold start ----
    do_reset("rst4");
    up_to_floor2();
    door_hold = 1'b1;
    run_to(14);
    door_hold = 1'b0;
    chk("s4_door_e14", door_open, 1);
    run_to(16);
    chk("s4_door_e16", door_open, 1);
    tick();
    chk("s4_door_e17", door_open, 0);
    chk("s4_st_e17", st, S_IDLE);

    // ---- reset mid-move ----
    do_reset("rst5");
    car_call = 4'b1000;
    tick();  // edge 0
    clear_inputs();
    run_to(10);
    chk("s5_floor_e10", floor, 2);
    chk("s5_st_e10", st, S_MOVE);
    rst = 1'b1;
    car_call = 4'b0001;
    hall_up = 4'b0010;
    tick();  // edge 11
    rst = 1'b0;
    clear_inputs();
    chk("s5_floor", floor, 0);
    chk("s5_st", st, S_IDLE);
    chk("s5_dir", direction, 0);
    chk("s5_leds", {up_led, dn_led, car_led}, 0);
    tick();
    chk("s5_discard", {up_led, dn_led, car_led}, 0);
    chk("s5_st_after", st, S_IDLE);

    // ---- 6-floor variant ----
    tick();
    rst6 = 1'b0;
    e = -1;
    car_call6 = 6'b100000;
    hall_up6  = 6'b100000;
    hall_dn6  = 6'b000001;
    tick();  // edge 0
    car_call6 = '0; hall_up6 = '0; hall_dn6 = '0;
    chk("s6_car_e0", car_led6, 6'b100000);
    chk("s6_up_e0", up_led6, 0);
    chk("s6_dn_e0", dn_led6, 0);
    tick();
    chk("s6_st_e1", st6, S_MOVE);
    chk("s6_dir_e1", direction6, 2'b01);
    run_to(20);
    chk("s6_floor_e20", floor6, 4);
    chk("s6_door_e20", door_open6, 0);
    tick();
    chk("s6_floor_e21", floor6, 5);
    chk("s6_door_e21", door_open6, 1);
    chk("s6_car_e21", car_led6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
